eth_pkg_rx: RTL

// - Receive-side checker for the byte-wide GMII-style stream produced by eth_pkg_top (tx_en/tx_data).
// - Detects preamble/SFD, parses DA/SA/EtherType, checks payload against the selected pattern.
// - Reports one result pulse per frame; keeps good/bad frame counters.
// - Sits at the loopback/PHY-receive end of the packet generator; the bench can connect io_tx_* straight to io_rx_*.

---
 rtl/eth_pkg_rx.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_pkg_rx.sv
// Receive-side checker for a byte-wide GMII-style stream: preamble/SFD, header, payload pattern, counters.
// Define ETH_PKG_RX_CRC_EN to treat the last 4 bytes as an FCS and check the Ethernet CRC-32 residue.
module eth_pkg_rx #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_PRE = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_enable,
  input  logic        io_da_filter_en,
  input  logic [47:0] io_da,
  input  logic [15:0] io_etype,
  input  logic [1:0]  io_payload_mode,
  input  logic        io_rx_dv,
  input  logic [7:0]  io_rx_data,
  output logic        io_frame_valid,
  output logic        io_frame_err,
  output logic [5:0]  io_err_flags,
  output logic [15:0] io_frame_len,
  input  logic        io_count_clr,
  output logic [47:0] io_good_count,
  output logic [31:0] io_bad_count
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, PLD, DROP} state_t;

  localparam int unsigned F_PRE  = 0;
  localparam int unsigned F_RUNT = 1;
  localparam int unsigned F_DA   = 2;
  localparam int unsigned F_ET   = 3;
  localparam int unsigned F_PLD  = 4;

  state_t      state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] len_q, len_d, len_inc;
  logic [5:0]  flags_q, flags_d;
  logic [7:0]  pat_q, pat_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [5:0]  err_flags_q, err_flags_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic [47:0] good_q, good_d;
  logic [31:0] bad_q, bad_d;
  logic [47:0] da_sh;
  logic [5:0]  end_flags;
  logic        pld_chk;
  logic [7:0]  pld_byte;

`ifdef ETH_PKG_RX_CRC_EN
  localparam int unsigned F_CRC = 5;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  logic [31:0] crc_q, crc_d;
  logic [31:0] dly_q, dly_d;
  logic [2:0]  dly_cnt_q, dly_cnt_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Register is LSB-first, so the residue is compared bit-reversed.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction
`endif

  assign len_inc = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
  assign da_sh   = io_da << (8 * hdr_idx_q);

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    hdr_idx_d   = hdr_idx_q;
    len_d       = len_q;
    flags_d     = flags_q;
    pat_d       = pat_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    err_flags_d = err_flags_q;
    frame_len_d = frame_len_q;
    good_d      = good_q;
    bad_d       = bad_q;
    end_flags   = flags_q;
    pld_chk     = 1'b0;
    pld_byte    = io_rx_data;
`ifdef ETH_PKG_RX_CRC_EN
    crc_d       = crc_q;
    dly_d       = dly_q;
    dly_cnt_d   = dly_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        pre_cnt_d = '0;
        hdr_idx_d = '0;
        len_d     = '0;
        flags_d   = '0;
        pat_d     = '0;
`ifdef ETH_PKG_RX_CRC_EN
        crc_d     = '1;
        dly_cnt_d = '0;
`endif
        if (io_rx_dv && io_enable) begin
          if (io_rx_data == 8'h55) begin
            state_d   = PRE;
            pre_cnt_d = 8'd1;
          end else begin
            state_d        = DROP;
            flags_d[F_PRE] = 1'b1;
          end
        end
      end
      PRE: begin
        if (!io_rx_dv) begin
          state_d = IDLE;
        end else if (io_rx_data == 8'h55) begin
          if (pre_cnt_q >= 8'(MAX_PRE)) begin
            state_d        = DROP;
            flags_d[F_PRE] = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end else if (io_rx_data == 8'hD5) begin
          state_d = HDR;
        end else begin
          state_d        = DROP;
          flags_d[F_PRE] = 1'b1;
        end
      end
      HDR: begin
        if (io_rx_dv) begin
          len_d = len_inc;
`ifdef ETH_PKG_RX_CRC_EN
          crc_d = crc_byte(crc_q, io_rx_data);
`endif
          if (io_da_filter_en && hdr_idx_q < 4'd6 && io_rx_data != da_sh[47:40]) flags_d[F_DA] = 1'b1;
          if (hdr_idx_q == 4'd12 && io_rx_data != io_etype[15:8]) flags_d[F_ET] = 1'b1;
          if (hdr_idx_q == 4'd13 && io_rx_data != io_etype[7:0])  flags_d[F_ET] = 1'b1;
          if (hdr_idx_q == 4'd13) state_d = PLD;
          else                    hdr_idx_d = hdr_idx_q + 4'd1;
        end
      end
      PLD: begin
        if (io_rx_dv) begin
          len_d = len_inc;
`ifdef ETH_PKG_RX_CRC_EN
          // Bytes are compared only once they leave the 4-deep delay line, so the FCS never is.
          crc_d = crc_byte(crc_q, io_rx_data);
          dly_d = {dly_q[23:0], io_rx_data};
          if (dly_cnt_q == 3'd4) begin
            pld_chk  = 1'b1;
            pld_byte = dly_q[31:24];
          end else begin
            dly_cnt_d = dly_cnt_q + 3'd1;
          end
`else
          pld_chk = 1'b1;
`endif
        end
      end
      DROP: ;
      default: state_d = IDLE;
    endcase

    if (pld_chk) begin
      unique case (io_payload_mode)
        2'd0: if (pld_byte != 8'h00) flags_d[F_PLD] = 1'b1;
        2'd1: if (pld_byte != 8'hFF) flags_d[F_PLD] = 1'b1;
        2'd2: begin
          if (pld_byte != pat_q) flags_d[F_PLD] = 1'b1;
          pat_d = pat_q + 8'd1;
        end
        default: ;
      endcase
    end

    if (!io_rx_dv && (state_q == HDR || state_q == PLD || state_q == DROP)) begin
      if (state_q != DROP) begin
        if (len_q < 16'(MIN_LEN)) end_flags[F_RUNT] = 1'b1;
`ifdef ETH_PKG_RX_CRC_EN
        if (bitrev32(crc_q) != CRC_RESIDUE) end_flags[F_CRC] = 1'b1;
`endif
      end
      valid_d     = (end_flags == '0);
      err_d       = (end_flags != '0);
      err_flags_d = end_flags;
      frame_len_d = len_q;
      state_d     = IDLE;
      if (end_flags == '0) good_d = good_q + 48'd1;
      else                 bad_d  = bad_q + 32'd1;
    end

    if (io_count_clr) begin
      good_d = '0;
      bad_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      hdr_idx_q   <= '0;
      len_q       <= '0;
      flags_q     <= '0;
      pat_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_flags_q <= '0;
      frame_len_q <= '0;
      good_q      <= '0;
      bad_q       <= '0;
`ifdef ETH_PKG_RX_CRC_EN
      crc_q       <= '1;
      dly_q       <= '0;
      dly_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      hdr_idx_q   <= hdr_idx_d;
      len_q       <= len_d;
      flags_q     <= flags_d;
      pat_q       <= pat_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_flags_q <= err_flags_d;
      frame_len_q <= frame_len_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
`ifdef ETH_PKG_RX_CRC_EN
      crc_q       <= crc_d;
      dly_q       <= dly_d;
      dly_cnt_q   <= dly_cnt_d;
`endif
    end
  end

  assign io_frame_valid = valid_q;
  assign io_frame_err   = err_q;
  assign io_err_flags   = err_flags_q;
  assign io_frame_len   = frame_len_q;
  assign io_good_count  = good_q;
  assign io_bad_count   = bad_q;

endmodule
